mc_controller: RTL

- Multicycle MIPS control unit that sits directly upstream of the 32-bit ALU.
- A Moore main FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write enables.
- A combinational ALU decoder turns aluop and funct into the 3-bit alucontrol the ALU consumes.
- Shared ALU encoding: AND=000, OR=001, ADD=010, SUB=011, SLT=101.

---
 rtl/mc_pkg.sv | 101 ++++++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/mc_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
//   - ALU operation codes consumed by the 32-bit ALU
//   - opcode / funct field values recognised by the controller
//   - main FSM state encoding (state_o reports these values)
//   - aluop codes passed from the FSM to the ALU decoder
//   - per-state control word and the helper that produces it
// Optional feature macro: MC_BNE_EN (adds the bne instruction, state 12).
package mc_pkg;

  localparam int OP_W = 6;
  localparam int FN_W = 6;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
`else
    S_JEX     = 4'd11
`endif
  } state_t;

  // Moore control word; branch_ne qualifies pcen with ~zero instead of zero.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s; unlisted bits are 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = {$bits(ctrl_t){1'b0}};
    case (s)
      S_FETCH:   begin c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MC_BNE_EN
      S_BNEEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch_ne = 1'b1; end
`endif
      default:   c = {$bits(ctrl_t){1'b0}};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational translation of aluop/funct into the ALU opcode.
//   aluop         in  2  00=ADD, 01=SUB, 10=use funct, 11=ADD
//   funct         in  6  instr[5:0], only meaningful when aluop=10
//   alucontrol    out 3  ALU opcode
//   illegal_funct out 1  funct not recognised while aluop=10
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0]      aluop,
  input  logic [FN_W-1:0] funct,
  output logic [2:0]      alucontrol,
  output logic            illegal_funct
);

  // Decode; an unknown funct still yields ADD so the write-back is harmless.
  always_comb begin
    alucontrol    = ALU_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin alucontrol = ALU_ADD; illegal_funct = 1'b1; end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (main FSM + ALU decoder).
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op, funct, zero       instruction fields and ALU zero flag
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc  datapath selects / write enables
//   pcen                  PC load (pcwrite, or taken branch)
//   alucontrol            3-bit ALU opcode
//   illegal               one-cycle pulse on unknown op (DECODE) or funct (RTYPEEX)
//   state_o               current FSM state
// Optional feature macro: MC_BNE_EN (bne instruction via state BNEEX=12).
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int FNW = FN_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [2:0]     alucontrol,
  output logic           illegal,
  output logic [3:0]     state_o
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   is_sw;
  logic   illegal_funct;

  function automatic logic op_legal(input logic [OPW-1:0] o);
    logic ok;
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // lw/sw choice comes from the flag latched in DECODE, not the live op.
  function automatic state_t next_state(input state_t s, input logic [OPW-1:0] o,
                                        input logic sw);
    state_t n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_RTYPEEX;
          OP_BEQ:       n = S_BEQEX;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       n = S_BNEEX;
`endif
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:  n = sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = S_MEMWB;
      S_RTYPEEX: n = S_ALUWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  assign nxt = next_state(state, op, is_sw);

  // Main FSM; the control word is loaded alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for(S_FETCH);
      is_sw <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= ctrl_for(nxt);
      if (state == S_DECODE) begin
        is_sw <= (op == OP_SW);
      end else begin
        is_sw <= is_sw;
      end
    end
  end

  alu_decoder u_alu_decoder (
    .aluop         (ctrl.aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .illegal_funct (illegal_funct)
  );

  // Write enables and pulses are gated by rst_n so a falling reset cancels
  // them before the next edge even though the registers hold FETCH values.
  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign memwrite = rst_n & ctrl.memwrite;
  assign irwrite  = rst_n & ctrl.irwrite;
  assign regwrite = rst_n & ctrl.regwrite;
  assign pcen     = rst_n & (ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.branch_ne & ~zero));
  assign illegal  = rst_n & (((state == S_DECODE) && !op_legal(op)) ||
                             ((state == S_RTYPEEX) && illegal_funct));
  assign state_o  = state;

endmodule
